// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the data-memory store buffer.
package riscv_mem_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;
  localparam int unsigned SB_AW            = 32;

  typedef struct packed {
    logic [SB_AW-3:0] waddr;
    logic [31:0]      data;
    logic [3:0]       be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: entry storage, head/tail pointers with wrap bit,
// full/empty, and flat visibility of every slot with its valid bit.
module store_buffer_fifo
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  sb_entry_t                  wr_entry,
  output sb_entry_t                  head_entry,
  output sb_entry_t                  entries [DEPTH],
  output logic [DEPTH-1:0]           valid,
  output logic [$clog2(DEPTH)-1:0]   head_idx,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  sb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // Slot contents need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[tail[IW-1:0]] <= wr_entry;
  end

  assign count      = tail - head;
  assign full       = (head[IW] != tail[IW]) && (head[IW-1:0] == tail[IW-1:0]);
  assign empty      = (head == tail);
  assign head_idx   = head[IW-1:0];
  assign head_entry = mem[head[IW-1:0]];

  always_comb begin
    logic [IW-1:0] offs;
    valid = '0;
    offs  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries[i[IW-1:0]] = mem[i[IW-1:0]];
      offs               = i[IW-1:0] - head[IW-1:0];
      valid[i[IW-1:0]]   = ({1'b0, offs} < count);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between core data port and single-port data RAM.
// STORE_BUF_FWD_EN: byte-wise load forwarding; otherwise loads to pending words stall.
module store_buffer
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned AW    = SB_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_re,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [31:0]   core_wd,
  input  logic [3:0]    core_be,
  output logic [31:0]   core_rd,
  output logic          core_stall,
  output logic          sb_empty,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wd,
  input  logic [31:0]   ram_rd
);

  localparam int unsigned IW = $clog2(DEPTH);

  sb_entry_t        wr_entry;
  sb_entry_t        head_entry;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [IW-1:0]    head_idx;
  logic             full;
  logic             empty;
  logic             load_acc;
  logic             store_acc;
  logic             drain;
  logic [AW-3:0]    load_waddr;
  logic             unused_ok;

  assign load_waddr = core_addr[AW-1:2];
  assign wr_entry   = '{waddr: load_waddr, data: core_wd, be: core_be};

  store_buffer_fifo #(.DEPTH(DEPTH)) fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (store_acc),
    .pop        (drain),
    .wr_entry   (wr_entry),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid),
    .head_idx   (head_idx),
    .full       (full),
    .empty      (empty)
  );

`ifdef STORE_BUF_FWD_EN
  assign core_stall = core_we && full;
  assign unused_ok  = ^core_addr[1:0];

  // Walk oldest to youngest so the youngest matching byte lands last.
  always_comb begin
    logic [IW-1:0] idx;
    core_rd = ram_rd;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_idx + k[IW-1:0];
      if (valid[idx] && (entries[idx].waddr == load_waddr)) begin
        for (int unsigned lane = 0; lane < 4; lane++) begin
          if (entries[idx].be[lane[1:0]]) core_rd[8*lane +: 8] = entries[idx].data[8*lane +: 8];
        end
      end
    end
  end
`else
  logic hazard;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i[IW-1:0]] && (entries[i[IW-1:0]].waddr == load_waddr)) hazard = 1'b1;
    end
  end

  assign core_stall = (core_we && full) || (core_re && hazard);
  assign core_rd    = ram_rd;
  assign unused_ok  = ^{core_addr[1:0], head_idx};
`endif

  assign load_acc  = core_re && !core_stall;
  assign store_acc = core_we && !core_stall;
  // Pending stores are discarded by reset, so none may reach RAM in that cycle.
  assign drain     = !reset && !load_acc && !empty;

  assign sb_empty = empty;
  assign ram_we   = drain;
  assign ram_be   = drain ? head_entry.be : '0;
  assign ram_addr = {(drain ? head_entry.waddr : load_waddr), 2'b00};
  assign ram_wd   = head_entry.data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; expectations follow STORE_BUF_FWD_EN.
module tb_store_buffer;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_re;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [3:0]  core_be;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        sb_empty;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_re    (core_re),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wd    (core_wd),
    .core_be    (core_be),
    .core_rd    (core_rd),
    .core_stall (core_stall),
    .sb_empty   (sb_empty),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_addr   (ram_addr),
    .ram_wd     (ram_wd),
    .ram_rd     (ram_rd)
  );

  // RAM model: async read, byte-enabled write, plus an ordered write log.
  logic [31:0] ram [0:255];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;
  wr_t wlog[$];

  assign ram_rd = ram[ram_addr[9:2]];

  always @(posedge clk) begin
    if (ram_we) begin
      for (int lane = 0; lane < 4; lane++)
        if (ram_be[lane]) ram[ram_addr[9:2]][8*lane +: 8] = ram_wd[8*lane +: 8];
      wlog.push_back('{addr: ram_addr, data: ram_wd, be: ram_be});
    end
  end

`ifdef STORE_BUF_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_re   = 1'b0;
    core_we   = 1'b0;
    core_addr = '0;
    core_wd   = '0;
    core_be   = '0;
  endtask

  // Issue a load (optionally with a same-cycle store), hold it while stalled, check result.
  task automatic load_wait(input string tag, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp_rd, input int exp_stalls);
    int stalls;
    stalls    = 0;
    core_re   = 1'b1;
    core_addr = a;
    core_we   = we;
    core_wd   = wd;
    core_be   = be;
    @(negedge clk);
    while (core_stall && stalls < 10) begin
      stalls++;
      tick();
      @(negedge clk);
    end
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "_rd"}, core_rd, exp_rd);
    tick();
    idle();
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!sb_empty && n < 20) begin
      n++;
      tick();
      @(negedge clk);
    end
    check(tag, 32'(sb_empty), 32'd1);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h40] = 32'hAABBCCDD;
    ram[8'h20] = 32'h12345678;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    @(negedge clk);
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    tick();

    core_re   = 1'b1;
    core_addr = 32'h100;
    @(negedge clk);
    check("ld_rd", core_rd, 32'hAABBCCDD);
    check("ld_empty", 32'(sb_empty), 32'd1);
    check("ld_ram_we", 32'(ram_we), 32'd0);
    check("ld_ram_addr", ram_addr, 32'h100);
    tick();
    idle();

    core_we   = 1'b1;
    core_addr = 32'h40;
    core_wd   = 32'h11223344;
    core_be   = 4'hF;
    @(negedge clk);
    check("st_stall", 32'(core_stall), 32'd0);
    check("st_ram_we0", 32'(ram_we), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("st_ram_we", 32'(ram_we), 32'd1);
    check("st_ram_addr", ram_addr, 32'h40);
    check("st_ram_wd", ram_wd, 32'h11223344);
    check("st_ram_be", 32'(ram_be), 32'hF);
    tick();
    @(negedge clk);
    check("st_empty_after", 32'(sb_empty), 32'd1);
    check("st_ram_we_after", 32'(ram_we), 32'd0);
    check("st_ram_content", ram[8'h10], 32'h11223344);
    tick();

    // Five stores; each paired with a load so the RAM port is busy and the queue fills.
    wlog.delete();
    for (int i = 0; i < 5; i++)
      load_wait("fill", 32'h200 + 32'(4*i), 1'b1, 32'hD000_0000 + 32'(i), 4'hF, 32'h0,
                (i == 4) ? 1 : 0);
    wait_empty("fill_drained");
    check("fill_nwrites", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("fill_order_addr", wlog[i].addr, 32'h200 + 32'(4*i));
      check("fill_order_data", wlog[i].data, 32'hD000_0000 + 32'(i));
    end

    core_we   = 1'b1;
    core_addr = 32'h80;
    core_wd   = 32'h000000EE;
    core_be   = 4'b0001;
    tick();
    idle();
    load_wait("fwd1", 32'h80, 1'b0, '0, '0, 32'h123456EE, (FWD != 0) ? 0 : 1);
    wait_empty("fwd1_drained");
    check("fwd1_ram", ram[8'h20], 32'h123456EE);

    ram[8'h20] = 32'h12345678;
    load_wait("yw_a", 32'h80, 1'b1, 32'h0000BBBB, 4'b0011, 32'h12345678, 0);
    load_wait("yw_b", 32'h80, 1'b1, 32'h000000CC, 4'b0001, 32'h1234BBBB, (FWD != 0) ? 0 : 1);
    load_wait("yw_c", 32'h80, 1'b0, '0, '0, 32'h1234BBCC, (FWD != 0) ? 0 : 1);
    wait_empty("yw_drained");
    check("yw_ram", ram[8'h20], 32'h1234BBCC);

    wlog.delete();
    for (int i = 0; i < 3; i++)
      load_wait("pend", 32'h180 + 32'(4*i), 1'b1, 32'hC000_0000 + 32'(i), 4'hF, 32'h0, 0);
    check("pend_nonempty", 32'(sb_empty), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ram_we", 32'(ram_we), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_empty", 32'(sb_empty), 32'd1);
    check("rst_mid_stall", 32'(core_stall), 32'd0);
    tick();
    tick();
    tick();
    check("rst_mid_nwrites", 32'(wlog.size()), 32'd0);
    check("rst_mid_ram", ram[8'h60], 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
